// File: rtl/axil_rd_lockstep_cmp_if.sv
// Bundle linking two lockstep AXI-lite read-path DUT output vectors to the comparator.
// Pure observation: 1-cycle registered results; nothing pushes back on either DUT.
interface axil_rd_lockstep_cmp_if #(
  parameter int S_COUNT    = 4,
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  localparam int W = S_COUNT * (4 + DATA_WIDTH) + M_COUNT * (5 + ADDR_WIDTH);

  logic [W-1:0]         a_sig;
  logic [W-1:0]         b_sig;
  logic                 enable;
  logic                 clear;
  logic                 armed;
  logic                 mismatch;
  logic [7:0]           mismatch_group;
  logic                 error;
  logic [7:0]           first_group;
  logic [CNT_WIDTH-1:0] first_cycle;
  logic [CNT_WIDTH-1:0] mismatch_count;
  logic [CNT_WIDTH-1:0] cycle_count;

  modport master (
    output a_sig, b_sig, enable, clear,
    input  armed, mismatch, mismatch_group, error, first_group, first_cycle,
           mismatch_count, cycle_count
  );

  modport slave (
    input  a_sig, b_sig, enable, clear,
    output armed, mismatch, mismatch_group, error, first_group, first_cycle,
           mismatch_count, cycle_count
  );
endinterface

// File: rtl/axil_rd_lockstep_cmp.sv
// Lockstep comparator of two AXI-lite read-path output vectors; results registered, latency 1.
// Observes only (no backpressure); sticky first-mismatch capture and saturating counters.
module axil_rd_lockstep_cmp #(
  parameter int S_COUNT       = 4,
  parameter int M_COUNT       = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 2,
  parameter int QUALIFY       = 1,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  axil_rd_lockstep_cmp_if.slave     cmp
);

  localparam int W  = S_COUNT * (4 + DATA_WIDTH) + M_COUNT * (5 + ADDR_WIDTH);
  localparam int O0 = 0;
  localparam int O1 = O0 + S_COUNT;
  localparam int O2 = O1 + S_COUNT;
  localparam int O3 = O2 + 2 * S_COUNT;
  localparam int O4 = O3 + S_COUNT * DATA_WIDTH;
  localparam int O5 = O4 + M_COUNT;
  localparam int O6 = O5 + M_COUNT;
  localparam int O7 = O6 + 3 * M_COUNT;
  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [W-1:0] a;
  logic [W-1:0] b;
  assign a = cmp.a_sig;
  assign b = cmp.b_sig;

  // Per-lane diffs; payload lanes are masked by their qualifying valids when QUALIFY is set.
  logic [S_COUNT-1:0] rresp_lane_d;
  logic [S_COUNT-1:0] rdata_lane_d;
  logic [M_COUNT-1:0] arprot_lane_d;
  logic [M_COUNT-1:0] araddr_lane_d;

  for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_s_lane
    logic q;
    assign q = (QUALIFY == 0) || (a[O1+gi] && b[O1+gi]);
    assign rresp_lane_d[gi] = q && (|(a[O2+2*gi +: 2] ^ b[O2+2*gi +: 2]));
    assign rdata_lane_d[gi] = q &&
        (|(a[O3+DATA_WIDTH*gi +: DATA_WIDTH] ^ b[O3+DATA_WIDTH*gi +: DATA_WIDTH]));
  end

  for (genvar gj = 0; gj < M_COUNT; gj++) begin : g_m_lane
    logic q;
    assign q = (QUALIFY == 0) || (a[O4+gj] && b[O4+gj]);
    assign arprot_lane_d[gj] = q && (|(a[O6+3*gj +: 3] ^ b[O6+3*gj +: 3]));
    assign araddr_lane_d[gj] = q &&
        (|(a[O7+ADDR_WIDTH*gj +: ADDR_WIDTH] ^ b[O7+ADDR_WIDTH*gj +: ADDR_WIDTH]));
  end

  logic [7:0] diff;
  always_comb begin
    diff    = '0;
    diff[0] = |(a[O0 +: S_COUNT] ^ b[O0 +: S_COUNT]);
    diff[1] = |(a[O1 +: S_COUNT] ^ b[O1 +: S_COUNT]);
    diff[2] = |rresp_lane_d;
    diff[3] = |rdata_lane_d;
    diff[4] = |(a[O4 +: M_COUNT] ^ b[O4 +: M_COUNT]);
    diff[5] = |(a[O5 +: M_COUNT] ^ b[O5 +: M_COUNT]);
    diff[6] = |arprot_lane_d;
    diff[7] = |araddr_lane_d;
  end

  logic [SW-1:0]        settle_cnt;
  logic                 armed;
  logic                 compare;
  logic                 mismatch_q;
  logic [7:0]           mgroup_q;
  logic                 error_q;
  logic [7:0]           fgroup_q;
  logic [CNT_WIDTH-1:0] fcycle_q;
  logic [CNT_WIDTH-1:0] mcount_q;
  logic [CNT_WIDTH-1:0] ccount_q;

  assign armed   = (settle_cnt == '0);
  assign compare = armed && cmp.enable;

  // clear takes effect first, so a coincident compared cycle sees the cleared state.
  logic                 err_base;
  logic [7:0]           fgroup_base;
  logic [CNT_WIDTH-1:0] fcycle_base;
  logic [CNT_WIDTH-1:0] mcount_base;
  logic [CNT_WIDTH-1:0] ccount_base;
  logic                 mismatch_n;
  logic [7:0]           mgroup_n;
  logic                 error_n;
  logic [7:0]           fgroup_n;
  logic [CNT_WIDTH-1:0] fcycle_n;
  logic [CNT_WIDTH-1:0] mcount_n;
  logic [CNT_WIDTH-1:0] ccount_n;

  always_comb begin
    err_base    = cmp.clear ? 1'b0 : error_q;
    fgroup_base = cmp.clear ? 8'h00 : fgroup_q;
    fcycle_base = cmp.clear ? '0 : fcycle_q;
    mcount_base = cmp.clear ? '0 : mcount_q;
    ccount_base = cmp.clear ? '0 : ccount_q;

    mismatch_n = 1'b0;
    mgroup_n   = 8'h00;
    error_n    = err_base;
    fgroup_n   = fgroup_base;
    fcycle_n   = fcycle_base;
    mcount_n   = mcount_base;
    ccount_n   = ccount_base;

    if (compare) begin
      mgroup_n   = diff;
      mismatch_n = |diff;
      ccount_n   = (ccount_base == CNT_MAX) ? CNT_MAX : ccount_base + 1'b1;
      if (|diff) begin
        mcount_n = (mcount_base == CNT_MAX) ? CNT_MAX : mcount_base + 1'b1;
        if (!err_base) begin
          error_n  = 1'b1;
          fgroup_n = diff;
          fcycle_n = ccount_base;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= SW'(SETTLE_CYCLES);
      mismatch_q <= 1'b0;
      mgroup_q   <= 8'h00;
      error_q    <= 1'b0;
      fgroup_q   <= 8'h00;
      fcycle_q   <= '0;
      mcount_q   <= '0;
      ccount_q   <= '0;
    end else begin
      if (settle_cnt != '0) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      mismatch_q <= mismatch_n;
      mgroup_q   <= mgroup_n;
      error_q    <= error_n;
      fgroup_q   <= fgroup_n;
      fcycle_q   <= fcycle_n;
      mcount_q   <= mcount_n;
      ccount_q   <= ccount_n;
    end
  end

  assign cmp.armed          = armed;
  assign cmp.mismatch       = mismatch_q;
  assign cmp.mismatch_group = mgroup_q;
  assign cmp.error          = error_q;
  assign cmp.first_group    = fgroup_q;
  assign cmp.first_cycle    = fcycle_q;
  assign cmp.mismatch_count = mcount_q;
  assign cmp.cycle_count    = ccount_q;

endmodule

// File: tb/tb_axil_rd_lockstep_cmp.sv
// Directed bench: three comparator instances (default, QUALIFY=0, CNT_WIDTH=4) share one stimulus.
module tb_axil_rd_lockstep_cmp;
  localparam int W = 292;
  // Bit positions in the default layout.
  localparam int B_ARREADY1 = 1;
  localparam int B_RVALID2  = 6;
  localparam int B_RDATA2_5 = 16 + 64 + 5;
  localparam int B_ARVALID0 = 144;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a_sig;
  logic [W-1:0] b_sig;
  logic         enable;
  logic         clear;
  logic [W-1:0] base;
  logic [W-1:0] f;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  axil_rd_lockstep_cmp_if #(.CNT_WIDTH(32)) if0 ();
  axil_rd_lockstep_cmp_if #(.CNT_WIDTH(32)) if1 ();
  axil_rd_lockstep_cmp_if #(.CNT_WIDTH(4))  if2 ();

  assign if0.a_sig = a_sig;  assign if0.b_sig = b_sig;
  assign if0.enable = enable; assign if0.clear = clear;
  assign if1.a_sig = a_sig;  assign if1.b_sig = b_sig;
  assign if1.enable = enable; assign if1.clear = clear;
  assign if2.a_sig = a_sig;  assign if2.b_sig = b_sig;
  assign if2.enable = enable; assign if2.clear = clear;

  axil_rd_lockstep_cmp #(.QUALIFY(1), .CNT_WIDTH(32)) dut0 (.clk(clk), .rst(rst), .cmp(if0));
  axil_rd_lockstep_cmp #(.QUALIFY(0), .CNT_WIDTH(32)) dut1 (.clk(clk), .rst(rst), .cmp(if1));
  axil_rd_lockstep_cmp #(.QUALIFY(1), .CNT_WIDTH(4))  dut2 (.clk(clk), .rst(rst), .cmp(if2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    base = '0;
    base[7:4]     = 4'hF;                      // s_rvalid all lanes
    base[15:8]    = 8'h1B;                     // rresp
    base[143:16]  = {4{32'hA5A5_1234}};        // rdata
    base[147:144] = 4'hF;                      // m_arvalid all lanes
    base[151:148] = 4'h5;                      // m_rready
    base[163:152] = 12'h3C5;                   // arprot
    base[291:164] = {4{32'h8000_0F00}};        // araddr
    rst = 1'b1; enable = 1'b1; clear = 1'b0;
    a_sig = base; b_sig = base;

    // Reset state
    step(); step();
    chk("rst_armed", 64'(if0.armed), 64'd0);
    chk("rst_error", 64'(if0.error), 64'd0);
    chk("rst_mismatch", 64'(if0.mismatch), 64'd0);
    chk("rst_ccount", 64'(if0.cycle_count), 64'd0);
    chk("rst_mcount2", 64'(if2.mismatch_count), 64'd0);

    // 100 identical cycles; two of them fall in the settle window
    rst = 1'b0;
    for (int i = 0; i < 100; i++) step();
    chk("id_armed", 64'(if0.armed), 64'd1);
    chk("id_error", 64'(if0.error), 64'd0);
    chk("id_ccount", 64'(if0.cycle_count), 64'd98);
    chk("id_mcount", 64'(if0.mismatch_count), 64'd0);

    // Clear, then rdata lane 2 bit 5 flipped at compared cycle 10
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_ccount", 64'(if0.cycle_count), 64'd1);
    for (int i = 0; i < 9; i++) step();
    f = base; f[B_RDATA2_5] = ~f[B_RDATA2_5]; b_sig = f;
    step();
    b_sig = base;
    chk("rd_mismatch", 64'(if0.mismatch), 64'd1);
    chk("rd_group", 64'(if0.mismatch_group), 64'h08);
    chk("rd_fcycle", 64'(if0.first_cycle), 64'd10);
    chk("rd_fgroup", 64'(if0.first_group), 64'h08);
    chk("rd_ccount", 64'(if0.cycle_count), 64'd11);
    step();
    chk("rd_after_mm", 64'(if0.mismatch), 64'd0);
    chk("rd_after_err", 64'(if0.error), 64'd1);
    chk("rd_after_mcount", 64'(if0.mismatch_count), 64'd1);

    // rdata differs while rvalid[2] is low on both sides
    clear = 1'b1; step(); clear = 1'b0;
    f = base; f[B_RVALID2] = 1'b0; a_sig = f;
    f[B_RDATA2_5] = ~f[B_RDATA2_5]; b_sig = f;
    step();
    a_sig = base; b_sig = base;
    chk("q1_mismatch", 64'(if0.mismatch), 64'd0);
    chk("q1_group", 64'(if0.mismatch_group), 64'h00);
    chk("q1_error", 64'(if0.error), 64'd0);
    chk("q0_group", 64'(if1.mismatch_group), 64'h08);
    chk("q0_mismatch", 64'(if1.mismatch), 64'd1);

    // Mid-run reset; mismatch on release cycle ignored, at settle+0 recorded
    rst = 1'b1; step();
    chk("mrst_error", 64'(if0.error), 64'd0);
    chk("mrst_armed", 64'(if0.armed), 64'd0);
    chk("mrst_ccount", 64'(if0.cycle_count), 64'd0);
    rst = 1'b0;
    f = base; f[B_ARVALID0] = ~f[B_ARVALID0]; b_sig = f;
    step();
    b_sig = base;
    chk("st_mismatch", 64'(if0.mismatch), 64'd0);
    chk("st_error", 64'(if0.error), 64'd0);
    chk("st_armed0", 64'(if0.armed), 64'd0);
    step();
    chk("st_armed1", 64'(if0.armed), 64'd1);
    f = base; f[B_ARREADY1] = ~f[B_ARREADY1]; b_sig = f;
    step();
    b_sig = base;
    chk("s0_mismatch", 64'(if0.mismatch), 64'd1);
    chk("s0_group", 64'(if0.mismatch_group), 64'h01);
    chk("s0_fcycle", 64'(if0.first_cycle), 64'd0);
    chk("s0_error", 64'(if0.error), 64'd1);
    chk("s0_ccount", 64'(if0.cycle_count), 64'd1);

    // Group 4 mismatch coincident with clear after prior error
    step();
    chk("pre_clr_ccount", 64'(if0.cycle_count), 64'd2);
    clear = 1'b1;
    f = base; f[B_ARVALID0] = ~f[B_ARVALID0]; b_sig = f;
    step();
    clear = 1'b0;
    chk("cm_error", 64'(if0.error), 64'd1);
    chk("cm_fgroup", 64'(if0.first_group), 64'h10);
    chk("cm_fcycle", 64'(if0.first_cycle), 64'd0);
    chk("cm_mcount", 64'(if0.mismatch_count), 64'd1);
    chk("cm_ccount", 64'(if0.cycle_count), 64'd1);

    // 20 mismatching compared cycles after a clear: 4-bit counters saturate
    clear = 1'b1; step(); clear = 1'b0;
    for (int i = 0; i < 19; i++) step();
    chk("sat_mcount", 64'(if2.mismatch_count), 64'd15);
    chk("sat_ccount", 64'(if2.cycle_count), 64'd15);
    chk("sat_fcycle", 64'(if2.first_cycle), 64'd0);
    chk("wide_mcount", 64'(if0.mismatch_count), 64'd20);
    chk("wide_ccount", 64'(if0.cycle_count), 64'd20);

    // enable low: no compare, counters frozen
    enable = 1'b0;
    step();
    chk("dis_mismatch", 64'(if0.mismatch), 64'd0);
    chk("dis_group", 64'(if0.mismatch_group), 64'h00);
    chk("dis_ccount", 64'(if0.cycle_count), 64'd20);
    chk("dis_mcount", 64'(if0.mismatch_count), 64'd20);
    chk("dis_error", 64'(if0.error), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axil_rd_lockstep_cmp.md
# axil_rd_lockstep_cmp

Synthesisable lockstep comparator for two AXI-lite read-path implementations driven by identical stimulus, such as a baseline read crossbar and its patched variant. It compares every DUT-driven read-path signal each cycle, with per-lane valid qualification, a post-reset settle window, a sticky first-mismatch capture and saturating counters. It sits beside the two instances in equivalence benches and on-FPGA shadow builds, replacing per-cycle immediate assertions with observable, registered error state.

## Interface
- S_COUNT, 4, slave interfaces per DUT
- M_COUNT, 4, master interfaces per DUT
- DATA_WIDTH, 32, rdata width
- ADDR_WIDTH, 32, araddr width
- SETTLE_CYCLES, 2, cycles after reset release with comparison disabled (0 = compare from first post-reset cycle)
- QUALIFY, 1, 0 = compare all bits every cycle; 1 = payload compared only where valid is high on both sides
- CNT_WIDTH, 32, width of counters and cycle stamp
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- a_sig  in  W  DUT A outputs. W = S_COUNT*(4+DATA_WIDTH) + M_COUNT*(5+ADDR_WIDTH). Concatenation, LSB first: group 0 s_arready[S], 1 s_rvalid[S], 2 s_rresp[2S], 3 s_rdata[S*DW], 4 m_arvalid[M], 5 m_rready[M], 6 m_arprot[3M], 7 m_araddr[M*AW]
- b_sig  in  W  DUT B outputs, same layout
- enable  in  1  compare enable; low freezes counters
- clear  in  1  synchronous clear of sticky state and counters
- armed  out  1  settle window elapsed
- mismatch  out  1  registered: mismatch seen last cycle
- mismatch_group  out  8  registered per-group mismatch of last cycle
- error  out  1  sticky: any mismatch since reset/clear
- first_group  out  8  mismatch_group at first mismatch
- first_cycle  out  CNT_WIDTH  cycle_count value at first mismatch
- mismatch_count  out  CNT_WIDTH  saturating count of mismatching cycles
- cycle_count  out  CNT_WIDTH  saturating count of compared cycles

## Operation
- Settle counter: loads SETTLE_CYCLES on rst; decrements each cycle while nonzero; armed = (counter == 0). clear does not restart it.
- Compared cycle: armed && enable.
- Group diff: bitwise XOR of group fields, OR-reduced per lane then per group.
- QUALIFY=1: rresp/rdata lane i compared only if a.s_rvalid[i] && b.s_rvalid[i]; arprot/araddr lane j only if a.m_arvalid[j] && b.m_arvalid[j]. Valid/ready groups 0,1,4,5 always compared. A valid disagreement is reported via its own group only.
- QUALIFY=0: all groups compared unconditionally.
- On a compared cycle: mismatch_group <= diff; mismatch <= |diff; cycle_count += 1 (saturate at all-ones); if |diff: mismatch_count += 1 (saturate); if !error: error <= 1, first_group <= diff, first_cycle <= cycle_count (pre-increment value).
- Non-compared cycle: mismatch, mismatch_group <= 0; counters and sticky state hold.
- clear: error, first_group, first_cycle, mismatch_count, cycle_count <= 0; a compared cycle coinciding with clear is evaluated against the cleared state (becomes first mismatch, first_cycle = 0, cycle_count <= 1, mismatch_count <= 1 if mismatching).

## Timing
- Reset: all outputs 0 (armed 0 when SETTLE_CYCLES>0, 1 when 0).
- Latency 1: sample in cycle N -> mismatch/error visible in N+1.
- No combinational path input->output.
- Reset asserted mid-run: all state cleared on the next edge, settle window restarts.
- Saturation: counters stick at 2^CNT_WIDTH-1; first_cycle captures the saturated value if reached.

## Test plan
- Identical a_sig/b_sig for 100 cycles, SETTLE_CYCLES=2 -> error=0, cycle_count=98, mismatch_count=0.
- Flip b s_rdata lane 2 bit 5 at compared cycle 10 with both rvalid[2]=1 -> next cycle mismatch=1, mismatch_group=8'h08, first_cycle=10, error stays 1 after stimulus matches again.
- QUALIFY=1, rdata differs while rvalid=0 both sides -> no mismatch; QUALIFY=0 same stimulus -> mismatch_group=8'h08.
- Mismatch on rst release cycle with SETTLE_CYCLES=2 -> ignored; mismatch at settle+0 -> recorded, first_cycle=0.
- Mismatch (group 4) coincident with clear after prior error -> error=1, first_group=8'h10, first_cycle=0, mismatch_count=1.
- CNT_WIDTH=4, mismatch every cycle 20 cycles -> mismatch_count and cycle_count hold 15.
